mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit owning the HI/LO register pair for the MIPS execute stage. It runs beside the single-cycle ALU and takes over the operations that cannot finish in one cycle. The pipeline controller stalls while `busy` is high. Multiplies complete after a configurable fixed latency. Divides use a 1-bit-per-cycle restoring divider.

## Interface
- `MUL_CYCLES`, default 5: cycles `busy` stays high for multiply-class ops; legal range 1..15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `start` in 1: launch the op on `op` this cycle. Sampled only in IDLE.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
- `a` in 32: rs operand (dividend / multiplicand / MT source).
- `b` in 32: rt operand (divisor / multiplier).
- `flush` in 1: exception abort; cancels any in-flight op.
- `busy` out 1: an op is in flight.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - MUL: counter runs; `busy`=1.
  - DIV: 32 iterations; `busy`=1.
- IDLE, `start`, op 0/1/6/7 -> MUL, counter = MUL_CYCLES-1. Product captured from `a`,`b` at acceptance.
- IDLE, `start`, op 2/3 -> DIV. At acceptance: operands captured as magnitudes, plus quotient and remainder sign flags (signed case).
- IDLE, `start`, op 4/5 -> HI or LO = `a` at that edge; state stays IDLE; `busy` never rises.
- `start` while not IDLE is ignored; operands are not re-captured.
- MULT / MULTU: {hi,lo} = 64-bit signed / unsigned a*b.
- MADD / MADDU: {hi,lo} = {hi,lo} + a*b (signed / unsigned, mod 2^64). The old {hi,lo} is read at completion, not at acceptance.
- DIV / DIVU: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x8000_0000 / 0xFFFF_FFFF signed: lo = 0x8000_0000, hi = 0.
  - Divide by zero, signed or unsigned: lo = 0xFFFF_FFFF, hi = `a`.
- HI/LO are written only at the completion edge. They hold their old values throughout an op.
- `flush` high in MUL/DIV: next edge -> IDLE, HI/LO unchanged, result discarded.
- `flush` and `start` in the same IDLE cycle: flush wins; nothing is accepted, including MTHI/MTLO.
- `rst_n` low, at any time including mid-op: immediately hi=0, lo=0, `busy`=0, state IDLE, counters 0.

## Timing
- Accept edge = edge E where IDLE and `start` are sampled high.
- `busy` is registered: it goes 1 after edge E and is combinational from state only.
- Multiply class: `busy` high for exactly MUL_CYCLES cycles. HI/LO update and `busy` fall on edge E+MUL_CYCLES.
- Divide: `busy` high for exactly 32 cycles. HI/LO update and `busy` fall on edge E+32.
- A new `start` is accepted on the edge where `busy` falls + 1, i.e. the first cycle with `busy`=0. Back-to-back issue has no dead cycle beyond that.
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after edge E.
- No combinational path from `start`/`op`/`a`/`b` to any output.

## Configuration
- `MDU_MADD_EN` defined:
  - ops 6/7 perform accumulate as above;
  - latency is the same as MULT.
- `MDU_MADD_EN` undefined:
  - ops 6/7 are ignored entirely: no state change, `busy` stays 0, HI/LO unchanged;
  - no 64-bit adder is synthesized.

## Test plan
- Reset, then MULT a=0xFFFF_FFFE, b=3 -> `busy` high 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. MULTU with the same operands -> hi=0x2, lo=0xFFFF_FFFA.
- DIV a=0xFFFF_FFF9 (-7), b=2 -> `busy` high 32 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=7, b=0 -> lo=0xFFFF_FFFF, hi=7.
- MTHI a=0x1234 and MTLO a=0x5678 on consecutive cycles -> `busy` never rises; hi=0x1234, lo=0x5678. Then MADD a=2, b=3 (macro on) -> hi=0x1234, lo=0x567E. With the macro off, the same MADD -> HI/LO unchanged, `busy`=0.
- DIVU started, `flush` asserted at cycle 10 -> `busy`=0 next cycle, HI/LO keep their pre-start values. A `start` during busy cycles 2-31 is ignored.
- `rst_n` pulsed low mid-DIV at cycle 20 -> hi=lo=0, `busy`=0 immediately. A fresh MULT a=5, b=5 then completes with lo=25 after 5 cycles.
- Signed overflow divide 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO for the execute stage.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate ops (6/7); otherwise they are ignored.
module mdu_iter #(
  parameter int unsigned MUL_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DLEN  = 2 * XLEN;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned DIV_ITERS = XLEN;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DLEN-1:0]   r_prod;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_dvs;
  logic              r_q_neg;
  logic              r_r_neg;
  logic              r_dz;
`ifdef MDU_MADD_EN
  logic              r_madd;
`endif

  logic              w_accept;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_signed;
  logic [DLEN-1:0]   w_a_ext;
  logic [DLEN-1:0]   w_b_ext;
  logic [DLEN-1:0]   w_prod;
  logic [DLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quo_nx;
  logic [XLEN-1:0]   w_q_fin;
  logic [XLEN-1:0]   w_r_fin;

  assign busy = (r_state != S_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Flush in IDLE blocks every acceptance, including MTHI/MTLO.
  assign w_accept = start & ~flush & (r_state == S_IDLE);
  assign w_signed = ~op[0];

  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: w_is_mul = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: w_is_mul = 1'b1;
`endif
      OP_DIV, OP_DIVU:   w_is_div = 1'b1;
      default:           ;
    endcase
  end

  // Low 64 bits of the extended product are correct for both signednesses.
  assign w_a_ext = w_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
  assign w_b_ext = w_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_a_mag = (w_signed & a[XLEN-1]) ? (XLEN'(0) - a) : a;
  assign w_b_mag = (w_signed & b[XLEN-1]) ? (XLEN'(0) - b) : b;

  // One restoring step: shift next dividend bit into the partial remainder.
  assign w_shift  = {r_rem, r_quo[XLEN-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_diff   = w_shift[XLEN-1:0] - r_dvs;
  assign w_rem_nx = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};
  assign w_q_fin  = r_q_neg ? (XLEN'(0) - w_quo_nx) : w_quo_nx;
  assign w_r_fin  = r_r_neg ? (XLEN'(0) - w_rem_nx) : w_rem_nx;

`ifdef MDU_MADD_EN
  // Accumulate reads HI/LO at completion, not at acceptance.
  assign w_mul_res = r_madd ? ({r_hi, r_lo} + r_prod) : r_prod;
`else
  assign w_mul_res = r_prod;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_dz    <= 1'b0;
`ifdef MDU_MADD_EN
      r_madd  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_prod  <= w_prod;
              r_cnt   <= CNT_W'(MUL_CYCLES - 1);
              r_state <= S_MUL;
`ifdef MDU_MADD_EN
              r_madd  <= op[2];
`endif
            end else if (w_is_div) begin
              r_quo   <= w_a_mag;
              r_rem   <= '0;
              r_dvs   <= w_b_mag;
              r_q_neg <= w_signed & (a[XLEN-1] ^ b[XLEN-1]);
              r_r_neg <= w_signed & a[XLEN-1];
              r_dz    <= (b == '0);
              r_cnt   <= CNT_W'(DIV_ITERS - 1);
              r_state <= S_DIV;
            end else if (op == OP_MTHI) begin
              r_hi <= a;
            end else if (op == OP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_mul_res;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (r_cnt == '0) begin
              // Divide by zero: all-ones quotient, remainder equals the dividend.
              r_lo    <= r_dz ? '1 : w_q_fin;
              r_hi    <= w_r_fin;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expected HI/LO queued at issue, checked at completion.
module tb_mdu_iter;

  localparam int unsigned MUL_CYCLES = 5;
  localparam int unsigned DIV_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_iter #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the architectural HI/LO effect of one op.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    if (o[0]) p = {32'b0, x} * {32'b0, y};
    else      p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
    case (o)
      3'd0, 3'd1: {m_hi, m_lo} = p;
      3'd2: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          m_lo = $signed(x) / $signed(y);
          m_hi = $signed(x) % $signed(y);
        end
      end
      3'd3: begin
        if (y == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = x;
        end else begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: begin
`ifdef MDU_MADD_EN
        {m_hi, m_lo} = {m_hi, m_lo} + p;
`endif
      end
    endcase
  endfunction

  function automatic int exp_cycles(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return MUL_CYCLES;
      3'd2, 3'd3: return DIV_CYCLES;
`ifdef MDU_MADD_EN
      3'd6, 3'd7: return MUL_CYCLES;
`endif
      default:    return 0;
    endcase
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    check({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, 64'(hi), 64'(e.hi));
      check({tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  // Called at a negedge; issues one op and returns at the first negedge with busy low.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit poke);
    int cyc;
    start = 1'b1; op = o; a = x; b = y;
    model(o, x, y);
    sb_q.push_back('{hi: m_hi, lo: m_lo});
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (poke && cyc == 5) begin
        start = 1'b1; op = 3'd4; a = ~x; b = ~y;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_len"}, 64'(cyc), 64'(exp_cycles(o)));
    compare_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op("divu_z",  3'd3, 32'd7, 32'd0, 1'b0);
    run_op("div_z_neg", 3'd2, 32'h8000_0000, 32'd0, 1'b0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd4; a = 32'h1234; b = '0;
    model(3'd4, 32'h1234, 32'd0);
    sb_q.push_back('{hi: m_hi, lo: m_lo});
    @(negedge clk);
    check("mthi_busy", 64'(busy), 64'd0);
    compare_out("mthi");
    op = 3'd5; a = 32'h5678;
    model(3'd5, 32'h5678, 32'd0);
    sb_q.push_back('{hi: m_hi, lo: m_lo});
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", 64'(busy), 64'd0);
    compare_out("mtlo");

    run_op("madd",  3'd6, 32'd2, 32'd3, 1'b0);
    run_op("maddu", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("madd_neg", 3'd6, 32'hFFFF_FFFF, 32'd7, 1'b1);

    // Flush mid-DIVU; a start during busy is ignored
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (k == 3) begin
        start = 1'b1; op = 3'd4; a = 32'hDEAD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (3) @(negedge clk);
    check("flush_idle", 64'(busy), 64'd0);

    // Flush and start together in IDLE: nothing accepted
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hCAFE;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    check("flush_start_hilo", {hi, lo}, {m_hi, m_lo});

    // Async reset mid-DIV
    start = 1'b1; op = 3'd2; a = 32'd12345; b = 32'd17;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mult_after_rst", 3'd0, 32'd5, 32'd5, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i % 4 == 1) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if (i % 2 == 0) rb = ~rb + 32'd1;
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
